// File: rtl/systolic_sched_if.sv
// Handshake and array-control bundle shared by the requesters/datapath (master)
// and the systolic_sched scheduler (slave).
interface systolic_sched_if #(
  parameter int unsigned SIZE = 4,
  parameter int unsigned LW   = 8
);
  localparam int unsigned RW = $clog2(SIZE);

  logic [1:0]         req_val;
  logic [1:0]         req_rdy;
  logic [1:0][LW-1:0] req_len;
  logic [1:0]         in_val;
  logic [1:0]         in_rdy;
  logic               arr_clr;
  logic               arr_mac_en;
  logic               arr_zero;
  logic               arr_owner;
  logic               out_val;
  logic               out_rdy;
  logic [RW-1:0]      out_row;
  logic               out_last;
  logic               out_owner;
  logic [1:0]         done;
  logic               busy;

  modport master (
    output req_val, req_len, in_val, out_rdy,
    input  req_rdy, in_rdy, arr_clr, arr_mac_en, arr_zero, arr_owner,
           out_val, out_row, out_last, out_owner, done, busy
  );

  modport slave (
    input  req_val, req_len, in_val, out_rdy,
    output req_rdy, in_rdy, arr_clr, arr_mac_en, arr_zero, arr_owner,
           out_val, out_row, out_last, out_owner, done, busy
  );
endinterface

// File: rtl/systolic_sched.sv
// Two-port scheduler/sequencer for a SIZE x SIZE systolic MAC array: clear, feed, flush, drain.
// Define SYSTOLIC_SCHED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module systolic_sched #(
  parameter int unsigned SIZE = 4,
  parameter int unsigned LW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  systolic_sched_if.slave  bus
);
  localparam int unsigned RW = $clog2(SIZE);
  localparam int unsigned FW = $clog2(2*SIZE-2);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN} state_t;

  state_t        state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic          owner_q, owner_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] beat_q, beat_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0]    done_q, done_d;
  logic          grant;

`ifdef SYSTOLIC_SCHED_PRIO_EN
  always_comb begin
    grant = bus.req_val[0] ? 1'b0 : bus.req_val[1];
  end
`else
  // On a tie (or no request) the port that was not granted last is offered.
  always_comb begin
    if (bus.req_val == 2'b11 || bus.req_val == 2'b00) grant = ~rr_ptr_q;
    else                                              grant = bus.req_val[1];
  end
`endif

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    len_d          = len_q;
    beat_d         = beat_q;
    flush_d        = flush_q;
    row_d          = row_q;
    done_d         = '0;
    bus.req_rdy    = '0;
    bus.in_rdy     = '0;
    bus.arr_clr    = 1'b0;
    bus.arr_mac_en = 1'b0;
    bus.arr_zero   = 1'b0;
    bus.out_val    = 1'b0;

    case (state_q)
      IDLE: begin
        bus.req_rdy[grant] = 1'b1;
        if (bus.req_val[grant]) begin
          state_d  = CLEAR;
          owner_d  = grant;
          rr_ptr_d = grant;
          len_d    = bus.req_len[grant];
          beat_d   = '0;
          flush_d  = '0;
          row_d    = '0;
        end
      end
      CLEAR: begin
        bus.arr_clr = 1'b1;
        state_d     = (len_q == '0) ? FLUSH : FEED;
      end
      FEED: begin
        bus.in_rdy[owner_q] = 1'b1;
        bus.arr_mac_en      = bus.in_val[owner_q];
        // Compare against K-1 so the final beat at K = 2^LW-1 never wraps the counter.
        if (bus.in_val[owner_q]) begin
          if (beat_q == len_q - LW'(1)) state_d = FLUSH;
          else                          beat_d  = beat_q + LW'(1);
        end
      end
      FLUSH: begin
        bus.arr_mac_en = 1'b1;
        bus.arr_zero   = 1'b1;
        if (flush_q == FW'(2*SIZE-3)) state_d = DRAIN;
        else                          flush_d = flush_q + FW'(1);
      end
      DRAIN: begin
        bus.out_val = 1'b1;
        if (bus.out_rdy) begin
          if (row_q == RW'(SIZE-1)) begin
            state_d         = IDLE;
            row_d           = '0;
            done_d[owner_q] = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      owner_q  <= 1'b0;
      len_q    <= '0;
      beat_q   <= '0;
      flush_q  <= '0;
      row_q    <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      flush_q  <= flush_d;
      row_q    <= row_d;
      done_q   <= done_d;
    end
  end

  assign bus.arr_owner = owner_q;
  assign bus.out_owner = owner_q;
  assign bus.out_row   = row_q;
  assign bus.out_last  = (state_q == DRAIN) && (row_q == RW'(SIZE-1));
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_systolic_sched.sv
// Directed self-checking bench for systolic_sched (SIZE=4, LW=8).
module tb_systolic_sched;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  systolic_sched_if #(.SIZE(4), .LW(8)) bus ();

  systolic_sched #(.SIZE(4), .LW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed view of the per-cycle control strobes: {clr, mac_en, zero, out_val, done[1:0]}
  function automatic logic [5:0] strobes();
    return {bus.arr_clr, bus.arr_mac_en, bus.arr_zero, bus.out_val, bus.done};
  endfunction

  initial begin
    logic [1:0] grants [4];
    logic [5:0] exp_s;
    int ngrant, mac_cnt, hs_cnt, rdy_seen;
    bit done_seen;

    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    bus.req_val = '0;
    bus.req_len = '0;
    bus.in_val  = '0;
    bus.out_rdy = 1'b0;

    // ---- Reset with both ports requesting
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_val = 2'b11;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_in_rdy", bus.in_rdy, 0);
    chk("rst_out_val", bus.out_val, 0);
    chk("rst_req_rdy", bus.req_rdy, 2'b10);

    // ---- Single job, port 0, K=3
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_val = 2'b01;
    bus.req_len[0] = 8'd3;
    bus.in_val = 2'b11;
    bus.out_rdy = 1'b1;
    #1;
    chk("j1_req_rdy", bus.req_rdy, 2'b01);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      bus.req_val = 2'b00;
      #1;
      exp_s = {c == 1, c >= 2 && c <= 10, c >= 5 && c <= 10, c >= 11 && c <= 14,
               (c == 15) ? 2'b01 : 2'b00};
      chk($sformatf("j1_strobes_c%0d", c), strobes(), exp_s);
      if (c >= 11 && c <= 14) begin
        chk($sformatf("j1_row_c%0d", c), bus.out_row, c - 11);
        chk($sformatf("j1_last_c%0d", c), bus.out_last, c == 14);
      end
      if (c == 3) chk("j1_in_rdy", bus.in_rdy, 2'b01);
    end
    chk("j1_idle", bus.busy, 0);

    // ---- Backpressure job, port 1, K=2
    bus.req_val = 2'b10;
    bus.req_len[1] = 8'd2;
    bus.in_val = 2'b11;
    #1;
    chk("j2_req_rdy", bus.req_rdy, 2'b10);
    mac_cnt = 0;
    hs_cnt = 0;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      bus.req_val = 2'b00;
      bus.in_val  = {!(c >= 3 && c <= 5), 1'b1};
      bus.out_rdy = !(c == 14 || c == 15);
      #1;
      if (bus.arr_mac_en && !bus.arr_zero) mac_cnt++;
      if (bus.out_val && bus.out_rdy) hs_cnt++;
      if (c == 4) begin
        chk("j2_stall_in_rdy", bus.in_rdy, 2'b10);
        chk("j2_stall_mac", bus.arr_mac_en, 0);
      end
      if (c == 14 || c == 15) chk($sformatf("j2_hold_row_c%0d", c), bus.out_row, 1);
      if (c == 17) chk("j2_owner", bus.out_owner, 1);
      if (c == 19) chk("j2_done", bus.done, 2'b10);
    end
    chk("j2_feed_beats", mac_cnt, 2);
    chk("j2_handshakes", hs_cnt, 4);

    // ---- Contention, both ports valid continuously, K=1
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_val = 2'b11;
    bus.req_len = {8'd1, 8'd1};
    bus.in_val = 2'b11;
    bus.out_rdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    ngrant = 0;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 200 && ngrant < 4; cyc++) begin
      #1;
      if (!bus.busy) begin
        grants[ngrant] = bus.req_rdy;
        ngrant++;
      end
      if (bus.done != 2'b00 && !done_seen) begin
        done_seen = 1'b1;
        chk("j3_done_while_idle", bus.busy, 0);
      end
      @(negedge clk);
    end
    bus.req_val = 2'b00;
    chk("j3_grant_count", ngrant, 4);
    for (int i = 0; i < ngrant; i++) begin
`ifdef SYSTOLIC_SCHED_PRIO_EN
      chk($sformatf("j3_grant%0d", i), grants[i], 2'b01);
`else
      chk($sformatf("j3_grant%0d", i), grants[i], (i % 2 == 0) ? 2'b10 : 2'b01);
`endif
    end
    for (int cyc = 0; cyc < 40 && bus.busy; cyc++) @(negedge clk);
    #1;
    chk("j3_drained", bus.busy, 0);

    // ---- K=0 job, port 0
    @(negedge clk);
    bus.req_val = 2'b01;
    bus.req_len[0] = 8'd0;
    #1;
    chk("j4_req_rdy", bus.req_rdy[0], 1);
    rdy_seen = 0;
    hs_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus.req_val = 2'b00;
      #1;
      if (bus.in_rdy != 2'b00) rdy_seen++;
      if (bus.out_val && bus.out_rdy) hs_cnt++;
      if (c == 1) chk("j4_clr", bus.arr_clr, 1);
      if (c == 2) chk("j4_flush_first", {bus.arr_zero, bus.arr_mac_en}, 2'b11);
      if (c == 12) chk("j4_done", bus.done, 2'b01);
    end
    chk("j4_no_in_rdy", rdy_seen, 0);
    chk("j4_rows", hs_cnt, 4);

    // ---- Reset mid-FEED (beat 2 of 5), then a clean K=2 job on port 1
    @(negedge clk);
    bus.req_val = 2'b01;
    bus.req_len[0] = 8'd5;
    bus.in_val = 2'b11;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.req_val = 2'b00;
      if (c == 3) rst_n = 1'b0;
      #1;
      if (c == 3) chk("j5_in_feed", bus.in_rdy, 2'b01);
    end
    done_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      if (c == 0) chk("j5_idle_after_rst", bus.busy, 0);
      if (bus.done != 2'b00) done_seen = 1'b1;
    end
    chk("j5_no_done", done_seen, 0);

    @(negedge clk);
    bus.req_val = 2'b10;
    bus.req_len[1] = 8'd2;
    #1;
    chk("j6_req_rdy", bus.req_rdy, 2'b10);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      bus.req_val = 2'b00;
      #1;
      exp_s = {c == 1, c >= 2 && c <= 9, c >= 4 && c <= 9, c >= 10 && c <= 13,
               (c == 14) ? 2'b10 : 2'b00};
      chk($sformatf("j6_strobes_c%0d", c), strobes(), exp_s);
      if (c >= 10 && c <= 13) chk($sformatf("j6_row_c%0d", c), bus.out_row, c - 10);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
